// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the MIPS datapath. Executes MULT, MULTU,
// DIV and DIVU one bit per clock and holds results in the architectural HI/LO
// registers, which also accept MTHI/MTLO writes while the unit is idle.
//
// Timing: start accepted at edge t0, Bits iterations at t0+1..t0+Bits, sign
// correction and HI/LO update at t0+Bits+1. done pulses in the cycle after
// that edge, and busy is high for the Bits+1 cycles in between.
//
// Configuration macro: MDU_DIV_EN
//   defined   : divider present, all four opcodes execute.
//   undefined : divider removed; a start with op[1]=1 is ignored entirely.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (aborts any operation)
//   start  in   launch operation (sampled only in IDLE)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   rs operand (multiplicand / dividend)
//   b      in   rt operand (multiplier / divisor)
//   hi_we  in   MTHI write enable (IDLE only, loses to start)
//   lo_we  in   MTLO write enable (IDLE only, loses to start)
//   wdata  in   MTHI/MTLO data
//   busy   out  operation in flight
//   done   out  one-cycle pulse when HI/LO receive a result
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int Bits = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [Bits-1:0] a,
    input  logic [Bits-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [Bits-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [Bits-1:0] hi,
    output logic [Bits-1:0] lo
);

    localparam int CntW = $clog2(Bits + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              neg_a_q;
    logic              neg_b_q;
    // Operand that is added/subtracted each step: multiplicand or divisor.
    logic [Bits-1:0]   opb_q;
    // Shared accumulator. Multiply: {partial product, multiplier}.
    // Divide: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*Bits:0]   acc_q;
    logic [Bits-1:0]   hi_q;
    logic [Bits-1:0]   lo_q;
    logic              done_q;
`ifdef MDU_DIV_EN
    logic              is_div_q;
    logic              div_zero_q;
    logic [Bits-1:0]   a_raw_q;
`endif

    logic              accept;
    logic              op_div;
    logic              signed_op;
    logic              sign_a;
    logic              sign_b;
    logic [Bits-1:0]   mag_a;
    logic [Bits-1:0]   mag_b;
    logic [Bits:0]     mul_sum;
    logic [2*Bits:0]   mul_step;
    logic [2*Bits:0]   step_d;
    logic [2*Bits-1:0] prod;
    logic [2*Bits-1:0] prod_fix;
    logic [Bits-1:0]   res_hi_d;
    logic [Bits-1:0]   res_lo_d;
`ifdef MDU_DIV_EN
    logic [Bits:0]     div_rem_sh;
    logic [Bits:0]     div_trial;
    logic [2*Bits:0]   div_step;
    logic [Bits-1:0]   quo_fix;
    logic [Bits-1:0]   rem_fix;
`endif

`ifdef MDU_DIV_EN
    assign op_div = op[1];
`else
    assign op_div = 1'b0;
`endif
    // Without the divider a divide start is simply not seen.
    assign accept = start & (op_div | ~op[1]);

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // value held and no latch is inferred.
    always_comb begin
        signed_op = ~op[0];
        sign_a    = signed_op & a[Bits-1];
        sign_b    = signed_op & b[Bits-1];
        mag_a     = sign_a ? -a : a;
        mag_b     = sign_b ? -b : b;

        // Radix-2 shift-add: add multiplicand when the multiplier LSB is set,
        // then shift the whole accumulator right by one.
        mul_sum  = acc_q[2*Bits:Bits] + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {1'b0, mul_sum, acc_q[Bits-1:1]};
        step_d   = mul_step;

        prod     = acc_q[2*Bits-1:0];
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        res_hi_d = prod_fix[2*Bits-1:Bits];
        res_lo_d = prod_fix[Bits-1:0];

`ifdef MDU_DIV_EN
        // Restoring division: shift next dividend bit into the remainder and
        // keep the subtraction only if it did not go negative.
        div_rem_sh = {acc_q[2*Bits-1:Bits], acc_q[Bits-1]};
        div_trial  = div_rem_sh - {1'b0, opb_q};
        if (!div_trial[Bits]) begin
            div_step = {div_trial, acc_q[Bits-2:0], 1'b1};
        end else begin
            div_step = {div_rem_sh, acc_q[Bits-2:0], 1'b0};
        end
        if (is_div_q) begin
            step_d = div_step;
        end

        // Quotient negated on differing signs; remainder follows the dividend.
        quo_fix = (neg_a_q ^ neg_b_q) ? -acc_q[Bits-1:0] : acc_q[Bits-1:0];
        rem_fix = neg_a_q ? -acc_q[2*Bits-1:Bits] : acc_q[2*Bits-1:Bits];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi_d = a_raw_q;
                res_lo_d = '1;
            end else begin
                res_hi_d = rem_fix;
                res_lo_d = quo_fix;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            opb_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= CALC;
                        cnt_q   <= CntW'(Bits);
                        neg_a_q <= sign_a;
                        neg_b_q <= sign_b;
                        opb_q   <= op_div ? mag_b : mag_a;
                        acc_q   <= {{(Bits+1){1'b0}}, (op_div ? mag_a : mag_b)};
`ifdef MDU_DIV_EN
                        is_div_q   <= op_div;
                        div_zero_q <= (b == '0);
                        a_raw_q    <= a;
`endif
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                CALC: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
